// File: rtl/word_matcher_pkg.sv
// word_matcher_pkg
//   Shared constants, types and helpers for the dictionary word matcher.
//   The end-of-word encoding (tuser set, tdata 0x00) is the same one used
//   by the SPI controller's stream generator, so both sides import it here.
package word_matcher_pkg;

  localparam int unsigned MAX_LEN = 8;   // pattern positions
  localparam int unsigned SLOTS   = 8;   // result table depth
  localparam int unsigned ID_W    = 8;   // word index width
  localparam int unsigned POS_W   = 4;   // position counter width

  // Position counter stops here; any value above MAX_LEN means "too long".
  localparam logic [POS_W-1:0] POS_SAT = 4'd9;

  // End-of-word beat convention.
  localparam logic       EOW_TUSER = 1'b1;
  localparam logic [7:0] EOW_TDATA = 8'h00;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [ID_W-1:0]  id_t;
  typedef logic [3:0]       count_t;

  // Byte lane idx of a 64-bit pattern/mask bus.
  function automatic logic [7:0] lane(input logic [63:0] bus, input logic [2:0] idx);
    return bus[{idx, 3'b000} +: 8];
  endfunction

  // Only word sizes 1..MAX_LEN can ever produce a match.
  function automatic logic size_ok(input logic [7:0] size);
    return (size >= 8'd1) && (size <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/word_matcher_masked_byte_compare.sv
// masked_byte_compare
//   Combinational masked byte compare. Mask bits at 0 are don't-care.
//   Ports:
//     data  - received character byte
//     char  - pattern character for the current position
//     mask  - compare mask for the current position
//     hit   - 1 when every masked bit of data equals char
module masked_byte_compare (
  input  logic [7:0] data,
  input  logic [7:0] char,
  input  logic [7:0] mask,
  output logic       hit
);

  assign hit = ((data ^ char) & mask) == 8'h00;

endmodule

// File: rtl/word_matcher.sv
// word_matcher
//   Streaming dictionary matcher. Consumes words as a byte stream terminated
//   by an end-of-word beat, compares each word against a masked pattern and
//   records the stream index of every matching word in an 8-slot table.
//   Ports:
//     aclk, aresetn        - clock, asynchronous active-low reset
//     s_axis_tvalid/tdata  - byte stream (no backpressure)
//     s_axis_tuser         - end-of-word marker (tdata ignored on that beat)
//     word_size            - required word length, 1..8
//     characters, masks    - pattern and compare mask, byte lane i = position i
//     result_ids           - slot k in bits [8k+7:8k]
//     result_count         - number of filled slots, 0..8
//     overflow             - sticky, a match arrived with the table full
//     word_index           - index of the word currently being received
module word_matcher
  import word_matcher_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic [7:0]  word_size,
  input  logic [63:0] characters,
  input  logic [63:0] masks,
  output logic [63:0] result_ids,
  output logic [3:0]  result_count,
  output logic        overflow,
  output logic [7:0]  word_index
);

  pos_t   pos;
  logic   mismatch;
  id_t    widx;
  id_t    slots [SLOTS];
  count_t count;
  logic   ovf;

  logic [7:0] cur_char;
  logic [7:0] cur_mask;
  logic       hit;
  logic       data_beat;
  logic       word_end;
  logic       in_range;
  logic       match;

  // pos[2:0] aliases once pos reaches 8; the compare result is then ignored.
  assign cur_char = lane(characters, pos[2:0]);
  assign cur_mask = lane(masks, pos[2:0]);

  masked_byte_compare u_cmp (
    .data (s_axis_tdata),
    .char (cur_char),
    .mask (cur_mask),
    .hit  (hit)
  );

  assign data_beat = s_axis_tvalid && (s_axis_tuser != EOW_TUSER);
  assign word_end  = s_axis_tvalid && (s_axis_tuser == EOW_TUSER);
  assign in_range  = pos < 4'(MAX_LEN);

  // Length check covers both short and over-long words: pos saturates at 9,
  // which can never equal a legal word_size.
  assign match = word_end && !mismatch && size_ok(word_size)
               && ({4'b0000, pos} == word_size);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pos      <= '0;
      mismatch <= 1'b0;
      widx     <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slots[i] <= '0;
      end
    end else if (data_beat) begin
      if (in_range && !hit) begin
        mismatch <= 1'b1;
      end
      if (pos != POS_SAT) begin
        pos <= pos + 4'd1;
      end
    end else if (word_end) begin
      pos      <= '0;
      mismatch <= 1'b0;
      widx     <= widx + 8'd1;
      if (match) begin
        if (count < 4'(SLOTS)) begin
          slots[count[2:0]] <= widx;
          count             <= count + 4'd1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    result_ids = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      result_ids[i*8 +: 8] = slots[i];
    end
  end

  assign result_count = count;
  assign overflow     = ovf;
  assign word_index   = widx;

endmodule

// File: doc/word_matcher.md
# word_matcher

Streaming match engine that sits directly downstream of the SPI controller's byte stream. It consumes dictionary words as a byte stream, where each word is terminated by a 0x00 beat with tuser set. Each completed word is compared against the configured masked search pattern, and the stream index of every matching word is recorded into a result table. The SPI side reads that table back as its 64-bit result-id vector.

## Interface
- MAX_LEN, 8: pattern positions supported; fixed by the 64-bit character/mask buses.
- SLOTS, 8: result slots; fixed by the 64-bit result bus.
- aclk  input  1  clock (same as SPI sclk).
- aresetn  input  1  asynchronous, active-low reset.
- s_axis_tvalid  input  1  beat valid. No tready: the block accepts every valid beat.
- s_axis_tdata  input  8  character byte.
- s_axis_tuser  input  1  end-of-word marker; tdata is ignored on this beat.
- word_size  input  8  required word length; valid range 1..8.
- characters  input  64  pattern; position i = characters[8i+7:8i].
- masks  input  64  compare mask; position i = masks[8i+7:8i]; 0 bits are don't-care.
- result_ids  output  64  slot k = result_ids[8k+7:8k] = word index of the k-th match.
- result_count  output  4  slots filled, 0..8.
- overflow  output  1  sticky; set when a match occurs with all 8 slots full.
- word_index  output  8  index of the word currently being received.

## Operation
- Internal state:
  - `pos`: 4-bit position counter, saturates at 9.
  - `mismatch`: 1-bit flag.
  - `word_index`: 8-bit counter.
  - Result slots, `result_count`, and `overflow`.
- Data beat (tvalid=1, tuser=0):
  - If pos<8: set `mismatch` when ((tdata ^ char[pos]) & mask[pos]) != 0.
  - pos <= min(pos+1, 9).
- Terminator beat (tvalid=1, tuser=1):
  - match = !mismatch && pos==word_size && 1<=word_size<=8.
  - pos<=0, mismatch<=0, word_index<=word_index+1 (wraps 255->0).
- On match:
  - If result_count<8: slot[result_count] <= word_index (value before the increment); result_count++.
  - Otherwise: overflow<=1; slots remain unchanged.
- Consequences of the match rule:
  - Empty words (back-to-back terminators) consume an index and never match.
  - Words longer than 8 never match.
  - word_size 0 or >8 never matches.
- A mask of 0xDF on letter positions gives case-insensitive compare.
- tvalid=0: no state change.
- Configuration inputs are sampled every beat. Software keeps them stable between enable and disable; changing them mid-word is undefined but must not corrupt the counters.
- There is no clear input. The SPI disable/enable sequence drives aresetn, which clears the table.

## Timing
- Reset (async assert, sync release): result_ids=0, result_count=0, overflow=0, word_index=0, pos=0, mismatch=0.
- Beats are accepted every cycle; sustained one byte per clock with no bubbles is required.
- Latency: result_ids, result_count, overflow, and word_index reflect a terminator beat in the cycle after the edge on which it is sampled (1 cycle).
- The compare uses only the current beat and the registered `mismatch`, so no multi-cycle pipeline is needed. The critical path is an 8-bit XOR/AND/OR-reduce plus the slot write decoder.
- Reset asserted mid-word: the partial word is discarded and the next word after release gets index 0.
- Ninth match: overflow sets on the same edge the ninth match would have been written; result_count stays 8.

## Structure
- Shared package holds:
  - MAX_LEN=8, SLOTS=8, ID_W=8.
  - Position-counter saturation value 9.
  - The end-of-word tuser convention, also used by the SPI controller's stream generator.
- Sub-module `masked_byte_compare`: inputs data, char, mask (8 bits each); output `hit`. It is combinational. The block instantiates one, indexed by `pos`.
- The rest is a single always block: position/mismatch tracker, word counter, result table.

## Test plan
- Exact match:
  - Stimulus: chars "cat" (characters[23:0]=0x746163), masks[23:0]=0xFFFFFF, word_size=3; stream "dog\0cat\0".
  - Response: result_count=1, result_ids[7:0]=0x01, word_index=2.
- Wildcard:
  - Stimulus: same pattern with masks[15:8]=0x00; stream "cut\0cat\0cart\0".
  - Response: slots 0x00 and 0x01, result_count=2. "cart" is rejected on length.
- Case-insensitive mask:
  - Stimulus: masks=0xDFDFDF; stream "CAT\0".
  - Response: result_ids[7:0]=0x00.
- Overflow:
  - Stimulus: 9 consecutive "cat\0" words.
  - Response: slots hold 0x00..0x07, result_count=8, overflow=1. A following non-matching word leaves all three unchanged.
- Wrap and empty words:
  - Stimulus: 256 bare terminators, then "cat\0".
  - Response: word_index reads 0 after the 256 terminators, the match records 0x00, and word_index=1.
- Reset mid-word:
  - Stimulus: send "ca", pulse aresetn low, release, send "cat\0".
  - Response: all outputs are 0 during reset; afterwards result_ids[7:0]=0x00 and result_count=1.
